// File: rtl/wav_stream_pkt_src.sv
// wav_stream_pkt_src
// Packetised valid/ready stream source. It emits packets of ctl_len+1 beats
// with tlast on the final beat. It inserts ctl_gap idle cycles between packets
// and stops after ctl_num packets (0 = never stop). tdata is a free-running
// counter that carries on across runs and is cleared only by reset.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   ctl_run   level-sensitive enable
//   ctl_len   packet length minus one
//   ctl_gap   idle cycles after each packet
//   ctl_num   packets to send, 0 = unlimited
//   tready    drain ready
//   tvalid    source valid
//   tdata     payload
//   tlast     last beat of packet
//   sts_busy  sending a packet or waiting in a gap
//   sts_done  packet limit reached
//   sts_pkt   packets completed since the last start
`timescale 1ns/1ps
module wav_stream_pkt_src #(
    parameter int unsigned DW = 8,
    parameter int unsigned LW = 8,
    parameter int unsigned GW = 4,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ctl_run,
    input  logic [LW-1:0] ctl_len,
    input  logic [GW-1:0] ctl_gap,
    input  logic [CW-1:0] ctl_num,
    input  logic          tready,
    output logic          tvalid,
    output logic [DW-1:0] tdata,
    output logic          tlast,
    output logic          sts_busy,
    output logic          sts_done,
    output logic [CW-1:0] sts_pkt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [LW-1:0] beat_q,  beat_d;
    logic [GW-1:0] gap_q,   gap_d;
    logic [LW-1:0] len_q,   len_d;
    logic [GW-1:0] gcfg_q,  gcfg_d;
    logic [CW-1:0] num_q,   num_d;
    logic [DW-1:0] data_q,  data_d;
    logic [CW-1:0] pkt_q,   pkt_d;
    logic [CW-1:0] pkt_inc;
    logic          last_beat;

    assign pkt_inc   = pkt_q + CW'(1);
    assign last_beat = (beat_q == len_q);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        gap_d   = gap_q;
        len_d   = len_q;
        gcfg_d  = gcfg_q;
        num_d   = num_q;
        data_d  = data_q;
        pkt_d   = pkt_q;

        case (state_q)
            ST_IDLE: begin
                if (ctl_run) begin
                    state_d = ST_DATA;
                    beat_d  = '0;
                    pkt_d   = '0;
                    len_d   = ctl_len;
                    gcfg_d  = ctl_gap;
                    num_d   = ctl_num;
                end
            end
            ST_DATA: begin
                // tvalid is 1 here, so tready alone means a transfer.
                if (tready) begin
                    data_d = data_q + DW'(1);
                    if (last_beat) begin
                        pkt_d  = pkt_inc;
                        beat_d = '0;
                        if ((num_q != '0) && (pkt_inc == num_q)) begin
                            state_d = ST_DONE;
                        end else if (!ctl_run) begin
                            state_d = ST_IDLE;
                        end else if (gcfg_q != '0) begin
                            state_d = ST_GAP;
                            gap_d   = gcfg_q;
                        end else begin
                            // Back-to-back packet: pick up fresh shape now.
                            len_d  = ctl_len;
                            gcfg_d = ctl_gap;
                        end
                    end else begin
                        beat_d = beat_q + LW'(1);
                    end
                end
            end
            ST_GAP: begin
                gap_d = gap_q - GW'(1);
                // Loaded with G, leaves on 1: exactly G idle cycles.
                if (gap_q == GW'(1)) begin
                    beat_d = '0;
                    if (ctl_run) begin
                        state_d = ST_DATA;
                        len_d   = ctl_len;
                        gcfg_d  = ctl_gap;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                if (!ctl_run) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            gap_q   <= '0;
            len_q   <= '0;
            gcfg_q  <= '0;
            num_q   <= '0;
            data_q  <= '0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
            len_q   <= len_d;
            gcfg_q  <= gcfg_d;
            num_q   <= num_d;
            data_q  <= data_d;
            pkt_q   <= pkt_d;
        end
    end

    // Outputs decode registers only; no path from tready or ctl_* inputs.
    assign tvalid   = (state_q == ST_DATA);
    assign tlast    = (state_q == ST_DATA) && last_beat;
    assign tdata    = data_q;
    assign sts_busy = (state_q == ST_DATA) || (state_q == ST_GAP);
    assign sts_done = (state_q == ST_DONE);
    assign sts_pkt  = pkt_q;

endmodule

// File: tb/tb_wav_stream_pkt_src.sv
`timescale 1ns/1ps
module tb_wav_stream_pkt_src;

    logic        clk;
    logic        rst;
    logic        ctl_run;
    logic [7:0]  ctl_len;
    logic [3:0]  ctl_gap;
    logic [15:0] ctl_num;
    logic        tready;
    logic        tvalid;
    logic [7:0]  tdata;
    logic        tlast;
    logic        sts_busy;
    logic        sts_done;
    logic [15:0] sts_pkt;

    // Narrow-data instance for the wrap scenario.
    logic        run4;
    logic [7:0]  len4;
    logic [3:0]  gap4;
    logic [15:0] num4;
    logic        tready4;
    logic        tvalid4;
    logic [3:0]  tdata4;
    logic        tlast4;
    logic        busy4;
    logic        done4;
    logic [15:0] pkt4;

    int checks = 0;
    int errors = 0;

    wav_stream_pkt_src #(.DW(8), .LW(8), .GW(4), .CW(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .ctl_run  (ctl_run),
        .ctl_len  (ctl_len),
        .ctl_gap  (ctl_gap),
        .ctl_num  (ctl_num),
        .tready   (tready),
        .tvalid   (tvalid),
        .tdata    (tdata),
        .tlast    (tlast),
        .sts_busy (sts_busy),
        .sts_done (sts_done),
        .sts_pkt  (sts_pkt)
    );

    wav_stream_pkt_src #(.DW(4), .LW(8), .GW(4), .CW(16)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .ctl_run  (run4),
        .ctl_len  (len4),
        .ctl_gap  (gap4),
        .ctl_num  (num4),
        .tready   (tready4),
        .tvalid   (tvalid4),
        .tdata    (tdata4),
        .tlast    (tlast4),
        .sts_busy (busy4),
        .sts_done (done4),
        .sts_pkt  (pkt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        int cyc;
        logic [3:0] bp_pat;

        rst     = 1'b0;
        ctl_run = 1'b0;
        ctl_len = 8'd0;
        ctl_gap = 4'd0;
        ctl_num = 16'd0;
        tready  = 1'b1;
        run4    = 1'b0;
        len4    = 8'd15;
        gap4    = 4'd0;
        num4    = 16'd2;
        tready4 = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_tvalid", tvalid, 0);
        check("rst_tlast", tlast, 0);
        check("rst_tdata", tdata, 0);
        check("rst_busy", sts_busy, 0);
        check("rst_done", sts_done, 0);
        check("rst_pkt", sts_pkt, 0);
        rst = 1'b1;
        tick();
        check("idle_tvalid", tvalid, 0);

        // Basic: len 3, gap 0, two packets, back-to-back
        ctl_len = 8'd3;
        ctl_gap = 4'd0;
        ctl_num = 16'd2;
        ctl_run = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            check("basic_tvalid", tvalid, 1);
            check("basic_tdata", tdata, i);
            check("basic_tlast", tlast, ((i % 4) == 3) ? 1 : 0);
            check("basic_busy", sts_busy, 1);
            tick();
        end
        check("basic_done", sts_done, 1);
        check("basic_tvalid_done", tvalid, 0);
        check("basic_pkt", sts_pkt, 2);
        check("basic_busy_done", sts_busy, 0);
        tick();
        check("basic_done_hold", sts_done, 1);
        ctl_run = 1'b0;
        tick();
        check("basic_done_clear", sts_done, 0);
        check("basic_idle_tvalid", tvalid, 0);

        // Backpressure: len 3, single packet, tready 1,0,0,1,...
        ctl_len = 8'd3;
        ctl_num = 16'd1;
        ctl_run = 1'b1;
        bp_pat  = 4'b1001;
        tick();
        check("bp_pkt_cleared", sts_pkt, 0);
        k   = 0;
        cyc = 0;
        while (k < 4 && cyc < 20) begin
            tready = bp_pat[cyc % 4];
            check("bp_tvalid", tvalid, 1);
            check("bp_tdata", tdata, 8 + k);
            check("bp_tlast", tlast, (k == 3) ? 1 : 0);
            tick();
            if (tready) k++;
            cyc++;
        end
        check("bp_all_beats", k, 4);
        tready = 1'b1;
        check("bp_done", sts_done, 1);
        check("bp_tvalid_after", tvalid, 0);
        check("bp_pkt", sts_pkt, 1);
        ctl_run = 1'b0;
        tick();

        // Gap: len 1, gap 3, unlimited
        ctl_len = 8'd1;
        ctl_gap = 4'd3;
        ctl_num = 16'd0;
        ctl_run = 1'b1;
        tick();
        k = 0;
        for (int c = 0; c < 10; c++) begin
            check("gap_tvalid", tvalid, ((c % 5) < 2) ? 1 : 0);
            check("gap_busy", sts_busy, 1);
            if ((c % 5) < 2) begin
                check("gap_tdata", tdata, 12 + k);
                check("gap_tlast", tlast, ((c % 5) == 1) ? 1 : 0);
                k++;
            end
            tick();
        end
        ctl_run = 1'b0;
        check("gap_p3_b0", tdata, 16);
        check("gap_p3_tlast0", tlast, 0);
        tick();
        check("gap_p3_b1", tdata, 17);
        check("gap_p3_tlast1", tlast, 1);
        tick();
        check("gap_stop_tvalid", tvalid, 0);
        check("gap_stop_busy", sts_busy, 0);
        check("gap_pkt", sts_pkt, 3);

        // Stop mid-packet: len 7, drop run after beat 2
        ctl_len = 8'd7;
        ctl_gap = 4'd0;
        ctl_num = 16'd0;
        ctl_run = 1'b1;
        tick();
        for (int b = 0; b < 8; b++) begin
            if (b == 2) ctl_run = 1'b0;
            check("stop_tvalid", tvalid, 1);
            check("stop_tdata", tdata, 18 + b);
            check("stop_tlast", tlast, (b == 7) ? 1 : 0);
            tick();
        end
        check("stop_idle_tvalid", tvalid, 0);
        check("stop_idle_busy", sts_busy, 0);
        check("stop_pkt", sts_pkt, 1);
        ctl_run = 1'b1;
        tick();
        check("restart_tdata", tdata, 26);
        check("restart_pkt", sts_pkt, 0);
        check("restart_tvalid", tvalid, 1);

        // Reset mid-packet at beat 5
        for (int b = 1; b <= 5; b++) tick();
        check("pre_rst_tdata", tdata, 31);
        #2;
        rst = 1'b0;
        #1;
        check("arst_tvalid", tvalid, 0);
        check("arst_tdata", tdata, 0);
        check("arst_busy", sts_busy, 0);
        check("arst_pkt", sts_pkt, 0);
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_tvalid", tvalid, 1);
        check("post_rst_tdata", tdata, 0);
        check("post_rst_tlast", tlast, 0);
        ctl_run = 1'b0;

        // Wrap on the 4-bit instance: len 15, two packets
        run4 = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) begin
            check("wrap_tvalid", tvalid4, 1);
            check("wrap_tdata", tdata4, i % 16);
            check("wrap_tlast", tlast4, ((i % 16) == 15) ? 1 : 0);
            tick();
        end
        check("wrap_done", done4, 1);
        check("wrap_pkt", pkt4, 2);
        check("wrap_tvalid_done", tvalid4, 0);
        tick();
        tick();
        check("wrap_done_hold", done4, 1);
        run4 = 1'b0;
        tick();
        check("wrap_done_clear", done4, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
